// File: rtl/rtc_nco_gen.sv
// Phase-accumulator NCO producing rt_clk/rt_tick for the core-local interruptor,
// with a small CTRL/INC/TICKS/STATUS register file on a valid/ready native bus.
module rtc_nco_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter logic [ACC_W-1:0] DEF_INC = ACC_W'(1407375)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  rt_clk,
  output logic                  rt_tick
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_INC    = 2'd1;
  localparam logic [1:0] SEL_TICKS  = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  logic              en_q, en_d;
  logic [ACC_W-1:0]  inc_q, inc_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              rt_clk_q, rt_clk_d;
  logic              rt_tick_q, rt_tick_d;
  logic [31:0]       ticks_q, ticks_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              wr_req, rd_req, clr;
  logic [1:0]        sel;
  logic [ACC_W-1:0]  acc_sum;
  logic              unused_addr;

  // Only address[3:2] selects a register; everything else aliases.
  assign unused_addr = ^{address[ADDR_W-1:4], address[1:0]};

  always_comb begin
    sel     = address[3:2];
    wr_req  = valid && (wstrb == {STRB_W{1'b1}});
    rd_req  = valid && (wstrb == '0);
    clr     = wr_req && (sel == SEL_CTRL) && wdata[1];
    acc_sum = acc_q + inc_q;

    en_d      = en_q;
    inc_d     = inc_q;
    acc_d     = acc_q;
    rt_clk_d  = rt_clk_q;
    rt_tick_d = 1'b0;
    ticks_d   = ticks_q;
    ready_d   = valid;
    rdata_d   = '0;

    if (wr_req && (sel == SEL_CTRL)) en_d  = wdata[0];
    if (wr_req && (sel == SEL_INC))  inc_d = ACC_W'(wdata);

    // Clear overrides accumulation; EN/INC changes apply from the next edge.
    if (clr) begin
      acc_d    = '0;
      rt_clk_d = 1'b0;
      ticks_d  = '0;
    end else if (en_q) begin
      acc_d     = acc_sum;
      rt_clk_d  = acc_sum[ACC_W-1];
      rt_tick_d = acc_sum[ACC_W-1] & ~rt_clk_q;
      ticks_d   = ticks_q + 32'(rt_tick_d);
    end

    if (rd_req) begin
      case (sel)
        SEL_CTRL:   rdata_d = DATA_W'(en_q);
        SEL_INC:    rdata_d = DATA_W'(inc_q);
        SEL_TICKS:  rdata_d = DATA_W'(ticks_q);
        SEL_STATUS: rdata_d = DATA_W'(rt_clk_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q      <= 1'b1;
      inc_q     <= DEF_INC;
      acc_q     <= '0;
      rt_clk_q  <= 1'b0;
      rt_tick_q <= 1'b0;
      ticks_q   <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      en_q      <= en_d;
      inc_q     <= inc_d;
      acc_q     <= acc_d;
      rt_clk_q  <= rt_clk_d;
      rt_tick_q <= rt_tick_d;
      ticks_q   <= ticks_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign rt_clk  = rt_clk_q;
  assign rt_tick = rt_tick_q;

endmodule

// File: tb/tb_rtc_nco_gen.sv
// Directed bench for rtc_nco_gen: register table, tick cadence, enable gating,
// clear-on-edge and asynchronous reset mid-read.
module tb_rtc_nco_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready, rt_clk, rt_tick;

  int checks = 0;
  int passes = 0;
  int cyc;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  rtc_nco_gen dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata),
    .ready   (ready),
    .rt_clk  (rt_clk),
    .rt_tick (rt_tick)
  );

  // Counts accumulation edges since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Call at a falling edge; request is captured at the next rising edge.
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input string nm, input logic [31:0] exp);
    valid = 1'b1; address = a; wdata = wd; wstrb = st;
    @(negedge clk);
    valid = 1'b0; wstrb = '0;
    $display("bus %-14s addr=0x%08h wstrb=0x%h wdata=0x%08h -> ready=%0b rdata=0x%08h",
             nm, a, st, wd, ready, rdata);
    check({nm, " ready"}, 32'(ready), 32'd1);
    check({nm, " rdata"}, rdata, exp);
  endtask

  // With INC = 2^30 starting from acc = 0: high on phases 2,3, rising on phase 2.
  task automatic nco_step(input string nm, input int k);
    @(negedge clk);
    check({nm, " rt_clk"},  32'(rt_clk),  32'((k % 4 == 2) || (k % 4 == 3)));
    check({nm, " rt_tick"}, 32'(rt_tick), 32'(k % 4 == 2));
  endtask

  initial begin
    int got;

    tbl[0]  = '{32'h0000_0004, 32'h0,         4'h0, 32'd1407375, "rd INC"};
    tbl[1]  = '{32'h0000_0000, 32'h0,         4'h0, 32'd1,       "rd CTRL"};
    tbl[2]  = '{32'h0000_0008, 32'h0,         4'h0, 32'd0,       "rd TICKS"};
    tbl[3]  = '{32'h0000_000C, 32'h0,         4'h0, 32'd0,       "rd STATUS"};
    tbl[4]  = '{32'h0000_0014, 32'h0,         4'h0, 32'd1407375, "rd INC alias"};
    tbl[5]  = '{32'h0000_0004, 32'h1234,      4'h3, 32'd0,       "wr INC partial"};
    tbl[6]  = '{32'h0000_0004, 32'h0,         4'h0, 32'd1407375, "rd INC kept"};
    tbl[7]  = '{32'h0000_0008, 32'h55,        4'hF, 32'd0,       "wr TICKS ro"};
    tbl[8]  = '{32'h0000_0008, 32'h0,         4'h0, 32'd0,       "rd TICKS kept"};
    tbl[9]  = '{32'h0000_0000, 32'hFFFF_FFFD, 4'hF, 32'd0,       "wr CTRL en"};
    tbl[10] = '{32'h0000_0100, 32'h0,         4'h0, 32'd1,       "rd CTRL alias"};

    #12;
    check("reset ready",   32'(ready),   32'd0);
    check("reset rdata",   rdata,        32'd0);
    check("reset rt_clk",  32'(rt_clk),  32'd0);
    check("reset rt_tick", 32'(rt_tick), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].nm, tbl[i].exp);
    @(negedge clk);
    check("idle ready", 32'(ready), 32'd0);

    // Default INC: first MSB crossing when k*1407375 >= 2^31, i.e. k = 1526.
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rt_tick) begin got = 1; break; end
      @(negedge clk);
    end
    check("first tick seen",  32'(got), 32'd1);
    check("first tick cycle", 32'(cyc), 32'd1526);
    check("first tick clk",   32'(rt_clk), 32'd1);

    // Quarter-scale increment after a clear: period 4.
    bus(32'h4, 32'h4000_0000, 4'hF, "wr INC 2^30", 32'd0);
    bus(32'h0, 32'h3,         4'hF, "wr CTRL clr", 32'd0);
    check("clr rt_clk",  32'(rt_clk),  32'd0);
    check("clr rt_tick", 32'(rt_tick), 32'd0);
    for (int k = 1; k <= 40; k++) nco_step("run", k);
    bus(32'h8, 32'h0, 4'h0, "rd TICKS 40", 32'd10);

    // Disable lands on the rising edge (k=42); output must freeze high.
    bus(32'h0, 32'h0, 4'hF, "wr CTRL dis", 32'd0);
    check("dis rt_clk", 32'(rt_clk), 32'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("frozen rt_clk",  32'(rt_clk),  32'd1);
      check("frozen rt_tick", 32'(rt_tick), 32'd0);
    end
    bus(32'h8, 32'h0, 4'h0, "rd TICKS frz", 32'd11);
    bus(32'hC, 32'h0, 4'h0, "rd STATUS frz", 32'd1);
    bus(32'h0, 32'h0, 4'h0, "rd CTRL dis", 32'd0);
    bus(32'h0, 32'h1, 4'hF, "wr CTRL en", 32'd0);
    check("en edge rt_clk",  32'(rt_clk),  32'd1);
    check("en edge rt_tick", 32'(rt_tick), 32'd0);
    for (int j = 1; j <= 8; j++) nco_step("resume", j + 2);
    bus(32'h8, 32'h0, 4'h0, "rd TICKS res", 32'd13);

    // Clear issued exactly on the edge that would rise.
    @(negedge clk);
    @(negedge clk);
    check("pre-clr rt_clk", 32'(rt_clk), 32'd0);
    bus(32'h0, 32'h3, 4'hF, "wr CTRL clr2", 32'd0);
    check("clr2 rt_clk",  32'(rt_clk),  32'd0);
    check("clr2 rt_tick", 32'(rt_tick), 32'd0);
    bus(32'h8, 32'h0, 4'h0, "rd TICKS clr", 32'd0);
    check("restart1 rt_clk",  32'(rt_clk),  32'd0);
    check("restart1 rt_tick", 32'(rt_tick), 32'd0);
    for (int k = 2; k <= 5; k++) nco_step("restart", k);

    // Asynchronous reset while a read response and a tick are live.
    valid = 1'b1; address = 32'h8; wstrb = 4'h0;
    @(posedge clk);
    #2;
    check("pre-rst ready",   32'(ready),   32'd1);
    check("pre-rst rt_tick", 32'(rt_tick), 32'd1);
    reset = 1'b0;
    #1;
    check("async ready",   32'(ready),   32'd0);
    check("async rdata",   rdata,        32'd0);
    check("async rt_clk",  32'(rt_clk),  32'd0);
    check("async rt_tick", 32'(rt_tick), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus(32'h4, 32'h0, 4'h0, "rd INC rst", 32'd1407375);
    bus(32'h8, 32'h0, 4'h0, "rd TICKS rst", 32'd0);
    bus(32'h0, 32'h0, 4'h0, "rd CTRL rst", 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rtc_nco_gen.md
Name: rtc_nco_gen

Overview:
Programmable numerically-controlled oscillator that produces the real-time clock consumed by the core-local interruptor's rt_clk input. It is usually set near 32.768 kHz. A phase accumulator runs on the system clock, and its MSB drives rt_clk. The block carries a small register file on the same valid/ready native bus used by the interruptor, so software can set the rate, gate the output and count rt_clk edges.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (fixed at 32; the register map assumes 32-bit words)
ACC_W, 32, phase accumulator width, >= 8
DEF_INC, 1407375, reset value of INC; 32.768 kHz from 100 MHz (32768*2^32/1e8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
valid  in  1  request valid
address  in  ADDR_W  request address; only address[3:2] is decoded
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  write strobes; all ones = write, zero = read
rdata  out  DATA_W  response data, meaningful while ready=1
ready  out  1  response valid
rt_clk  out  1  generated real-time clock, registered
rt_tick  out  1  one-cycle pulse on each rt_clk rising edge

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - acc=0, rt_clk=0, rt_tick=0, TICKS=0, EN=1, INC=DEF_INC.
  - ready=0, rdata=0.
- Register map, selected by address[3:2]; higher address bits are ignored, so the map aliases:
  - 0x0 CTRL, R/W:
    - bit0 EN.
    - bit1 CLR, write-only and self-clearing; reads return 0.
  - 0x4 INC, R/W: phase increment, ACC_W bits, zero-extended on read.
  - 0x8 TICKS, RO: 32-bit count of rt_clk rising edges; wraps 0xFFFFFFFF->0.
  - 0xC STATUS, RO: bit0 = current rt_clk.
  - Writes to RO registers are ignored. All unused bits read 0.
- Bus handshake:
  - Every cycle with valid=1 produces ready=1 exactly one cycle later (registered). Back-to-back requests give back-to-back responses.
  - rdata is registered with ready. It is 0 when ready=0 and 0 for write responses.
  - wstrb == all ones: write. wstrb == 0: read.
  - Any partial strobe is acknowledged (ready=1, rdata=0) with no state change.
- Accumulator, each clk edge:
  - If CLR is written this cycle: acc<=0, rt_clk<=0, TICKS<=0, rt_tick<=0. Clear wins over accumulation.
  - Else if EN=1: acc<=acc+INC, mod 2^ACC_W.
  - Else (EN=0): acc, rt_clk and TICKS hold.
- rt_clk and rt_tick:
  - rt_clk is the registered MSB of the updated accumulator.
  - rt_tick=1 in the same cycle rt_clk goes 0->1, and TICKS increments in that cycle.
- Register updates:
  - A write to INC is used from the next accumulation onward; acc is not disturbed.
  - A write to EN takes effect on the next edge.
  - A read of TICKS in the same cycle as an increment returns the pre-increment value.
- INC rules:
  - INC=0 with EN=1 freezes rt_clk; this is legal.
  - INC >= 2^(ACC_W-1) is legal. rt_clk is still the MSB, but the output frequency aliases, and software must avoid this range.
- Output frequency = INC*f_clk/2^ACC_W. rt_clk jitter is at most 1 clk period; long-term frequency is exact.
- Reset asserted mid-transaction: the pending response is dropped (ready forced 0) and all state returns to reset values.

Test Plan:
1. Release reset, read 0x4 then 0x0 -> ready one cycle after each valid; rdata=1407375, then 0x1; rt_clk toggles.
2. Write CLR, write INC=0x40000000 (ACC_W=32) -> rt_tick pulses on accumulation cycles 2,6,10,...; after 40 accumulation cycles TICKS reads 10; rt_clk high 2 cycles, low 2 cycles.
3. Write EN=0 while rt_clk=1 -> rt_clk stays 1, TICKS unchanged for 100 cycles. Write EN=1 -> ticks resume with period 4.
4. Write CLR in the cycle a rising edge would occur -> rt_tick=0, rt_clk=0, TICKS reads 0, acc restarts from 0.
5. Write INC with wstrb=4'h3, data 0x1234 -> ready=1, INC still reads the previous value. Write TICKS with wstrb=4'hF -> TICKS unchanged.
6. Assert reset between clock edges mid-read -> ready, rt_clk and rt_tick drop to 0 immediately. After release, INC reads DEF_INC and TICKS reads 0.
